// File: rtl/ram2p_pkg.sv
// Shared constants, collision classification and address helper for ram2p_sync.
package ram2p_pkg;

  localparam int unsigned RD_FIRST = 0;
  localparam int unsigned WR_FIRST = 1;

  // WR: A writes and B reads the shared word; RW: A reads and B writes it.
  typedef enum logic [1:0] {
    NONE,
    WW,
    WR,
    RW
  } coll_t;

  function automatic logic addr_ok(input int unsigned adr, input int unsigned nw);
    return adr < nw;
  endfunction

endpackage

// File: rtl/ram2p_if.sv
// Access bus of the dual-port RAM: both port requests plus status/flag returns.
interface ram2p_if #(
  parameter int unsigned WS = 8,
  parameter int unsigned AW = 8,
  parameter int unsigned CW = 8
);
  logic          ena_a, ena_b;
  logic          wri_a, wri_b;
  logic [AW-1:0] adr_a, adr_b;
  logic [WS-1:0] wda_a, wda_b;
  logic          oe_a, oe_b;
  logic          clr_cnt;
  logic          vld_a, vld_b;
  logic          oor_a, oor_b;
  logic          coll;
  logic [CW-1:0] coll_cnt;

  modport master (
    output ena_a, ena_b, wri_a, wri_b, adr_a, adr_b, wda_a, wda_b, oe_a, oe_b, clr_cnt,
    input  vld_a, vld_b, oor_a, oor_b, coll, coll_cnt
  );

  modport slave (
    input  ena_a, ena_b, wri_a, wri_b, adr_a, adr_b, wda_a, wda_b, oe_a, oe_b, clr_cnt,
    output vld_a, vld_b, oor_a, oor_b, coll, coll_cnt
  );
endinterface

// File: rtl/ram2p_coll.sv
// Collision detection between the two ports, coll pulse and saturating counter.
module ram2p_coll
  import ram2p_pkg::*;
#(
  parameter int unsigned AW = 8,
  parameter int unsigned CW = 8
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          ena_a,
  input  logic          ena_b,
  input  logic          wri_a,
  input  logic          wri_b,
  input  logic          inr_a,
  input  logic          inr_b,
  input  logic [AW-1:0] adr_a,
  input  logic [AW-1:0] adr_b,
  input  logic          clr_cnt,
  output coll_t         ctype,
  output logic          coll,
  output logic [CW-1:0] coll_cnt
);

  // Classify this cycle's accesses; two reads of one word are harmless.
  always_comb begin
    ctype = NONE;
    if (ena_a && ena_b && inr_a && inr_b && (adr_a == adr_b)) begin
      if (wri_a && wri_b) ctype = WW;
      else if (wri_a)     ctype = WR;
      else if (wri_b)     ctype = RW;
    end
  end

  // Register the collision pulse and count it; a clear wins over an increment.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      coll     <= 1'b0;
      coll_cnt <= '0;
    end else begin
      coll <= (ctype != NONE);
      if (clr_cnt)
        coll_cnt <= '0;
      else if ((ctype != NONE) && (coll_cnt != '1))
        coll_cnt <= coll_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ram2p_sync.sv
// Single-clock true dual-port RAM with read-during-write mode and optional output stage.
module ram2p_sync
  import ram2p_pkg::*;
#(
  parameter int unsigned WS    = 8,
  parameter int unsigned NW    = 136,
  parameter int unsigned AW    = 8,
  parameter int unsigned WMODE = 0,
  parameter int unsigned OREG  = 0,
  parameter int unsigned CW    = 8
) (
  input  logic          ck,
  input  logic          rst,
  ram2p_if.slave        bus,
  output logic [WS-1:0] rda_a,
  output logic [WS-1:0] rda_b
);

  logic [WS-1:0] mem [NW];
  logic          inr_a, inr_b, we_a, we_b;
  coll_t         ctype;
  logic          coll1;
  logic [WS-1:0] old_a, old_b, nxt_a, nxt_b;
  logic [WS-1:0] q1_a, q1_b;
  logic          v1_a, v1_b, o1_a, o1_b;
  logic [WS-1:0] qo_a, qo_b;
  logic          vo_a, vo_b, oo_a, oo_b, co;

  assign inr_a = addr_ok(32'(bus.adr_a), NW);
  assign inr_b = addr_ok(32'(bus.adr_b), NW);

  ram2p_coll #(.AW(AW), .CW(CW)) u_coll (
    .ck       (ck),
    .rst      (rst),
    .ena_a    (bus.ena_a),
    .ena_b    (bus.ena_b),
    .wri_a    (bus.wri_a),
    .wri_b    (bus.wri_b),
    .inr_a    (inr_a),
    .inr_b    (inr_b),
    .adr_a    (bus.adr_a),
    .adr_b    (bus.adr_b),
    .clr_cnt  (bus.clr_cnt),
    .ctype    (ctype),
    .coll     (coll1),
    .coll_cnt (bus.coll_cnt)
  );

  assign we_a = bus.ena_a & bus.wri_a & inr_a;
  assign we_b = bus.ena_b & bus.wri_b & inr_b & (ctype != WW);

  // Array update; gated by rst so an access sampled during reset never lands.
  always_ff @(posedge ck) begin
    if (!rst) begin
      if (we_a) mem[bus.adr_a] <= bus.wda_a;
      if (we_b) mem[bus.adr_b] <= bus.wda_b;
    end
  end

  // Current contents at each port address; out-of-range reads return zero.
  always_comb begin
    old_a = '0;
    old_b = '0;
    if (inr_a) old_a = mem[bus.adr_a];
    if (inr_b) old_b = mem[bus.adr_b];
  end

  // Write-first forwards whatever value the array ends up holding for that word.
  always_comb begin
    nxt_a = old_a;
    nxt_b = old_b;
    if (WMODE == WR_FIRST) begin
      if (we_a)              nxt_a = bus.wda_a;
      else if (ctype == RW)  nxt_a = bus.wda_b;
      if ((ctype == WW) || (ctype == WR)) nxt_b = bus.wda_a;
      else if (we_b)         nxt_b = bus.wda_b;
    end
  end

  // First read stage: data captured only on enabled accesses, flags every cycle.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      q1_a <= '0;
      q1_b <= '0;
      v1_a <= 1'b0;
      v1_b <= 1'b0;
      o1_a <= 1'b0;
      o1_b <= 1'b0;
    end else begin
      v1_a <= bus.ena_a;
      v1_b <= bus.ena_b;
      o1_a <= bus.ena_a & ~inr_a;
      o1_b <= bus.ena_b & ~inr_b;
      if (bus.ena_a) q1_a <= nxt_a;
      if (bus.ena_b) q1_b <= nxt_b;
    end
  end

  if (OREG != 0) begin : g_oreg
    logic [WS-1:0] q2_a, q2_b;
    logic          v2_a, v2_b, o2_a, o2_b, c2;

    // Output stage: flags follow stage one, data advances only behind a valid.
    always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
        q2_a <= '0;
        q2_b <= '0;
        v2_a <= 1'b0;
        v2_b <= 1'b0;
        o2_a <= 1'b0;
        o2_b <= 1'b0;
        c2   <= 1'b0;
      end else begin
        v2_a <= v1_a;
        v2_b <= v1_b;
        o2_a <= o1_a;
        o2_b <= o1_b;
        c2   <= coll1;
        if (v1_a) q2_a <= q1_a;
        if (v1_b) q2_b <= q1_b;
      end
    end

    assign qo_a = q2_a;
    assign qo_b = q2_b;
    assign vo_a = v2_a;
    assign vo_b = v2_b;
    assign oo_a = o2_a;
    assign oo_b = o2_b;
    assign co   = c2;
  end else begin : g_noreg
    assign qo_a = q1_a;
    assign qo_b = q1_b;
    assign vo_a = v1_a;
    assign vo_b = v1_b;
    assign oo_a = o1_a;
    assign oo_b = o1_b;
    assign co   = coll1;
  end

  assign bus.vld_a = vo_a;
  assign bus.vld_b = vo_b;
  assign bus.oor_a = oo_a;
  assign bus.oor_b = oo_b;
  assign bus.coll  = co;

  assign rda_a = bus.oe_a ? qo_a : 'z;
  assign rda_b = bus.oe_b ? qo_b : 'z;

endmodule
